bus_irq_ctrl: RTL and testbench
===============================

Name: bus_irq_ctrl

Overview:
Parametrised interrupt controller on the internal register bus, generalising the single-register interrupt latch. It collects DATAWIDTH request lines with per-bit edge or level mode, a bus-programmable enable mask, write-1-to-clear pending status and a raw-status view. It drives one registered irq output with a programmable hold-off after each new pending bit. It sits between peripheral request sources and the CPU interrupt input.

Parameters:
ADDR, 0, byte base address; block occupies four 32-bit words ADDR+0..ADDR+12.
DATAWIDTH, 32, number of request lines (1..BUS_DATA_WIDTH).
HOLDOFF, 15, irq suppression cycles after a new pending bit (0 = none).
MODE_RST, 0, reset value of MODE register (bit=1 level, 0 edge).
ENABLE_RST, 0, reset value of ENABLE register.

Ports:
bus_clk  input  1  clock; all state on rising edge.
bus_reset  input  1  reset, asynchronous, active-high.
bus_in  input  BUS_IN_WIDTH  internal bus request (bus_addr, bus_re, bus_we, bus_wr_data).
bus_out  output  BUS_OUT_WIDTH  read data, rd_ack, wr_ack, irq field.
trig  input  DATAWIDTH  interrupt requests, synchronous to bus_clk.
irq  output  1  registered interrupt request.

Behaviour:
- One clock, bus_clk; reset is asynchronous and active-high (bus_reset). On assertion, immediately: PEND=0, trig_d=0, count=0, irq=0, ENABLE=ENABLE_RST, MODE=MODE_RST.
- Register map (decode on bus_addr[BUS_ADDR_WIDTH-1:2], low two bits ignored):
  +0 PEND: read pending; write 1 clears bit, 0 no effect.
  +4 ENABLE: read/write.
  +8 MODE: read/write; 1 = level, 0 = edge.
  +12 RAW: read-only current trig; writes acked, ignored.
- Bus: rd_ack = decode & bus_re, wr_ack = decode & bus_we, combinational, same cycle. Read data zero-extended to BUS_DATA_WIDTH, all zeros when not acked. bus_out irq field is always 0.
- Set term per bit i: edge mode set = trig[i] & ~trig_d[i]; level mode set = trig[i]. trig_d is registered every cycle.
- PEND next = (PEND & ~clr) | set, where clr = bus_wr_data on a PEND write, else 0. Set wins over a simultaneous clear.
- Level bit with source still high cannot be cleared. Software must quiesce the source first.
- MODE change takes effect next cycle. An edge-to-level switch with trig high sets the bit.
- new = |(PEND_next & ~PEND): any bit rising 0->1 loads count = HOLDOFF. Otherwise count decrements to 0 and saturates there. count width = clog2(HOLDOFF+1), minimum 1.
- irq next = (count == 0) & |(PEND & ENABLE), registered.
- Latency, edge mode, HOLDOFF=0: trig rises at cycle N, PEND set at N+1, irq high at N+2.
- With HOLDOFF=H, irq first rises H cycles later. A further new bit during hold-off restarts the count.
- ENABLE masks irq only. Disabled bits still latch in PEND.
- irq drops one cycle after the last enabled pending bit clears or is disabled.
- Reset mid-hold-off: count cleared, irq low immediately.

Test Plan:
- Reset: assert bus_reset mid-cycle -> irq=0 without waiting for a clock; after release, reads give PEND=0, ENABLE=ENABLE_RST, MODE=MODE_RST.
- Edge, HOLDOFF=15: ENABLE=0x1, pulse trig[0] for 3 cycles -> PEND=0x1 (single set); irq rises 17 cycles after the trig edge; write 0x1 to +0 -> PEND=0, irq low 2 cycles later.
- Level: MODE=0x4, ENABLE=0x4, hold trig[2] high, write 0x4 to PEND -> PEND stays 0x4, irq stays high; drop trig[2], write 0x4 -> PEND=0, irq falls.
- Simultaneous: trig[5] edge in the same cycle as a PEND write of 0x20 -> PEND bit 5 remains 1.
- Hold-off restart: HOLDOFF=15, trig[0] edge at t0, trig[1] edge at t0+10 -> irq first high at t0+10+16+1 (count reloaded); masked bit trig[3] with ENABLE bit 3=0 -> PEND bit 3 set, irq unaffected.
- Bus decode: read +12 with trig=0xA5A5 -> 0x0000A5A5 with rd_ack; access ADDR+16 -> no ack, data 0; write +12 -> wr_ack, no state change.

Source files
------------

// File: rtl/bus_irq_ctrl.sv
// Bus-mapped interrupt controller: edge/level request capture, enable mask,
// write-1-to-clear pending status, raw view and hold-off before irq.
module bus_irq_ctrl #(
  parameter int unsigned BUS_ADDR_WIDTH = 16,
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter int unsigned BUS_IN_WIDTH   =
    BUS_ADDR_WIDTH + BUS_DATA_WIDTH + 2,
  parameter int unsigned BUS_OUT_WIDTH  = BUS_DATA_WIDTH + 3,
  parameter int unsigned ADDR           = 0,
  parameter int unsigned DATAWIDTH      = 32,
  parameter int unsigned HOLDOFF        = 15,
  parameter logic [BUS_DATA_WIDTH-1:0] MODE_RST   = '0,
  parameter logic [BUS_DATA_WIDTH-1:0] ENABLE_RST = '0
) (
  input  logic                     bus_clk,
  input  logic                     bus_reset,
  input  logic [BUS_IN_WIDTH-1:0]  bus_in,
  output logic [BUS_OUT_WIDTH-1:0] bus_out,
  input  logic [DATAWIDTH-1:0]     trig,
  output logic                     irq
);

  localparam int AW = BUS_ADDR_WIDTH;
  localparam int BW = BUS_DATA_WIDTH;
  localparam int DW = DATAWIDTH;
  localparam int CW =
    (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [AW-1:0] BASE = AW'(ADDR);
  localparam logic [CW-1:0] HOLD = CW'(HOLDOFF);

  logic [AW-1:0] addr;
  logic          re;
  logic          we;
  logic [BW-1:0] wdata;

  assign addr  = bus_in[BUS_IN_WIDTH-1 -: AW];
  assign re    = bus_in[BW+1];
  assign we    = bus_in[BW];
  assign wdata = bus_in[BW-1:0];

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata};

  logic [AW-3:0] off;
  logic          hit;
  logic [1:0]    idx;

  // Word offset wraps on addresses below the base, so one compare suffices.
  assign off = addr[AW-1:2] - BASE[AW-1:2];
  assign hit = (off[AW-3:2] == '0);
  assign idx = off[1:0];

  logic [DW-1:0] pend_q, pend_d;
  logic [DW-1:0] en_q, en_d;
  logic [DW-1:0] mode_q, mode_d;
  logic [DW-1:0] trig_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          irq_q, irq_d;

  logic [DW-1:0] clr;
  logic [DW-1:0] set;
  logic          rd_ack;
  logic          wr_ack;
  logic [DW-1:0] rsel;
  logic [BW-1:0] rdata;

  assign rd_ack = hit & re;
  assign wr_ack = hit & we;

  always_comb begin
    rsel = '0;
    if (rd_ack) begin
      unique case (idx)
        2'd0: rsel = pend_q;
        2'd1: rsel = en_q;
        2'd2: rsel = mode_q;
        2'd3: rsel = trig;
      endcase
    end
  end

  always_comb begin
    rdata         = '0;
    rdata[DW-1:0] = rsel;
  end

  assign bus_out = {rdata, rd_ack, wr_ack, 1'b0};

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    clr    = '0;
    if (wr_ack) begin
      unique case (idx)
        2'd0: clr    = wdata[DW-1:0];
        2'd1: en_d   = wdata[DW-1:0];
        2'd2: mode_d = wdata[DW-1:0];
        2'd3: ;
      endcase
    end
  end

  // Set is applied after the clear, so a live request always survives it.
  assign set    = (mode_q & trig) | (~mode_q & trig & ~trig_q);
  assign pend_d = (pend_q & ~clr) | set;

  always_comb begin
    cnt_d = '0;
    if (|(pend_d & ~pend_q))
      cnt_d = HOLD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
    irq_d = (cnt_q == '0) & |(pend_q & en_q);
  end

  always_ff @(posedge bus_clk or posedge bus_reset) begin
    if (bus_reset) begin
      pend_q <= '0;
      trig_q <= '0;
      cnt_q  <= '0;
      irq_q  <= 1'b0;
      en_q   <= ENABLE_RST[DW-1:0];
      mode_q <= MODE_RST[DW-1:0];
    end else begin
      pend_q <= pend_d;
      trig_q <= trig;
      cnt_q  <= cnt_d;
      irq_q  <= irq_d;
      en_q   <= en_d;
      mode_q <= mode_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_bus_irq_ctrl.sv
// Directed bench for bus_irq_ctrl: reset, edge/level capture, hold-off,
// masking, set-vs-clear priority and address decode.
module tb_bus_irq_ctrl;

  localparam logic [15:0] A = 16'h0100;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        re;
  logic        we;
  logic [31:0] wdata;
  logic [49:0] bus_in;
  logic [34:0] bus_out;
  logic [31:0] trig;
  logic        irq;

  int passed;
  int total;

  assign bus_in = {addr, re, we, wdata};

  bus_irq_ctrl #(
    .ADDR      (32'h0100),
    .DATAWIDTH (32),
    .HOLDOFF   (15)
  ) dut (
    .bus_clk   (clk),
    .bus_reset (rst),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .trig      (trig),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] o,
                           input logic [31:0] d);
    addr  = A + o;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic bus_read(input  logic [15:0] o,
                          output logic [31:0] d,
                          output logic        ack);
    addr = A + o;
    re   = 1'b1;
    #1;
    d    = bus_out[34:3];
    ack  = bus_out[2];
    re   = 1'b0;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got %h want %h", nm, got, exp);
    else
      passed++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        a;
    total++;
    if (irq !== 1'b0)
      $display("FAIL rst_irq got %b want 0", irq);
    else
      passed++;
    bus_read(0, d, a);
    chk("rst_pend", d, 32'h0);
    bus_read(4, d, a);
    chk("rst_en", d, 32'h0);
    bus_read(8, d, a);
    chk("rst_mode", d, 32'h0);
  endtask

  task automatic test_edge();
    logic [31:0] d;
    logic        a;
    int          n;
    bus_write(4, 32'h1);
    trig = 32'h1;
    step();
    n = 1;
    bus_read(0, d, a);
    chk("edge_pend", d, 32'h1);
    while (!irq && n < 40) begin
      if (n == 3) trig = '0;
      step();
      n++;
    end
    chk("edge_lat", n, 17);
    bus_read(0, d, a);
    chk("edge_single", d, 32'h1);
    bus_write(0, 32'h1);
    bus_read(0, d, a);
    chk("edge_clr", d, 32'h0);
    chk("edge_irq_hold", {31'b0, irq}, 32'h1);
    step();
    chk("edge_irq_drop", {31'b0, irq}, 32'h0);
  endtask

  task automatic test_level();
    logic [31:0] d;
    logic        a;
    int          n;
    bus_write(8, 32'h4);
    bus_write(4, 32'h4);
    trig = 32'h4;
    step();
    n = 1;
    while (!irq && n < 40) begin
      step();
      n++;
    end
    chk("lvl_lat", n, 17);
    bus_write(0, 32'h4);
    bus_read(0, d, a);
    chk("lvl_noclr", d, 32'h4);
    step();
    chk("lvl_irq", {31'b0, irq}, 32'h1);
    trig = '0;
    bus_write(0, 32'h4);
    bus_read(0, d, a);
    chk("lvl_clr", d, 32'h0);
    step();
    chk("lvl_irq_drop", {31'b0, irq}, 32'h0);
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    logic        a;
    bus_write(8, 32'h0);
    bus_write(4, 32'h20);
    trig = 32'h20;
    step();
    trig = '0;
    step();
    trig = 32'h20;
    bus_write(0, 32'h20);
    bus_read(0, d, a);
    chk("sim_setwins", d, 32'h20);
    trig = '0;
    bus_write(0, 32'h20);
    bus_read(0, d, a);
    chk("sim_clr", d, 32'h0);
  endtask

  task automatic test_back_to_back();
    int n;
    bus_write(4, 32'h3);
    repeat (20) step();
    trig = 32'h1;
    step();
    n = 1;
    while (!irq && n < 60) begin
      if (n == 10) trig = 32'h3;
      step();
      n++;
    end
    chk("restart_lat", n, 27);
  endtask

  task automatic test_masked();
    logic [31:0] d;
    logic        a;
    logic        seen;
    trig = '0;
    bus_write(0, 32'h3);
    step();
    chk("mask_pre", {31'b0, irq}, 32'h0);
    repeat (20) step();
    trig = 32'h8;
    step();
    trig = '0;
    bus_read(0, d, a);
    chk("mask_pend", d, 32'h8);
    seen = 1'b0;
    repeat (30) begin
      step();
      seen |= irq;
    end
    chk("mask_irq", {31'b0, seen}, 32'h0);
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic        a;
    bus_write(0, 32'hFFFF_FFFF);
    trig = 32'h0000_A5A5;
    bus_read(12, d, a);
    chk("raw_data", d, 32'h0000_A5A5);
    chk("raw_ack", {31'b0, a}, 32'h1);
    bus_read(13, d, a);
    chk("raw_lowbits", d, 32'h0000_A5A5);
    addr = A + 16'd12;
    re   = 1'b1;
    #1;
    chk("rd_noWack", {31'b0, bus_out[1]}, 32'h0);
    chk("irq_field", {31'b0, bus_out[0]}, 32'h0);
    re = 1'b0;
    bus_read(16, d, a);
    chk("oob_data", d, 32'h0);
    chk("oob_ack", {31'b0, a}, 32'h0);
    addr  = A + 16'd12;
    wdata = 32'hFFFF_FFFF;
    we    = 1'b1;
    #1;
    chk("raw_wack", {31'b0, bus_out[1]}, 32'h1);
    chk("raw_wnoRack", {31'b0, bus_out[2]}, 32'h0);
    step();
    addr  = A + 16'd16;
    wdata = 32'h0;
    #1;
    chk("oob_wack", {31'b0, bus_out[1]}, 32'h0);
    step();
    we = 1'b0;
    bus_read(4, d, a);
    chk("dec_en", d, 32'h3);
    bus_read(8, d, a);
    chk("dec_mode", d, 32'h0);
    bus_read(0, d, a);
    chk("dec_pend", d, 32'h0000_A5A5);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic        a;
    int          n;
    n = 0;
    while (!irq && n < 40) begin
      step();
      n++;
    end
    chk("ar_pre", {31'b0, irq}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_irq", {31'b0, irq}, 32'h0);
    trig = '0;
    #10;
    rst = 1'b0;
    step();
    bus_read(0, d, a);
    chk("ar_pend", d, 32'h0);
    bus_read(4, d, a);
    chk("ar_en", d, 32'h0);
    bus_read(8, d, a);
    chk("ar_mode", d, 32'h0);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    addr   = '0;
    re     = 1'b0;
    we     = 1'b0;
    wdata  = '0;
    trig   = '0;
    #12;
    rst = 1'b0;
    step();
    test_reset();
    test_edge();
    test_level();
    test_simultaneous();
    test_back_to_back();
    test_masked();
    test_decode();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
